// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver for the pong paddles: conditions the raw lines, frames bytes,
// decodes make/break/extended sequences into a held-key vector and keeps a byte history.
module ps2_key_tracker #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [3:0]  key_held,
    output logic        code_valid,
    output logic [7:0]  code_byte,
    output logic [31:0] last_codes,
    output logic        frame_err
);
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FL_LAST  = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0] FCNT_ONE = FW'(1);
    localparam logic [IW-1:0] TO_LAST  = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_ONE = IW'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

    // Odd parity holds when data bits and parity bit together XOR to one
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic          clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
    logic          clk_filt_r, data_filt_r, clk_filt_d_r;
    logic [FW-1:0] clk_fcnt_r, data_fcnt_r;
    logic          fall_s;
    state_t        state_r, state_n;
    logic [2:0]    bit_cnt_r, bit_cnt_n;
    logic [7:0]    shift_r, shift_n;
    logic          parity_r, parity_n;
    logic [IW-1:0] idle_cnt_r;
    logic          good_s, bad_frame_s, timeout_s, err_s;
    logic          ext_r, brk_r, code_valid_r, frame_err_r;
    logic [3:0]    key_held_r;
    logic [7:0]    code_byte_r;
    logic [31:0]   last_codes_r;

    // Two-flop synchronizers; lines idle high
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    // Clock glitch filter: level follows only after FILTER_LEN differing samples in a row
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_filt_r <= 1'b1;
            clk_fcnt_r <= '0;
        end else if (clk_sync_r == clk_filt_r) begin
            clk_fcnt_r <= '0;
        end else if (clk_fcnt_r == FL_LAST) begin
            clk_filt_r <= clk_sync_r;
            clk_fcnt_r <= '0;
        end else begin
            clk_fcnt_r <= clk_fcnt_r + FCNT_ONE;
        end
    end

    // Data glitch filter, same rule as the clock
    always_ff @(posedge clk) begin
        if (reset) begin
            data_filt_r <= 1'b1;
            data_fcnt_r <= '0;
        end else if (data_sync_r == data_filt_r) begin
            data_fcnt_r <= '0;
        end else if (data_fcnt_r == FL_LAST) begin
            data_filt_r <= data_sync_r;
            data_fcnt_r <= '0;
        end else begin
            data_fcnt_r <= data_fcnt_r + FCNT_ONE;
        end
    end

    // Delayed filtered clock for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_filt_d_r <= 1'b1;
        end else begin
            clk_filt_d_r <= clk_filt_r;
        end
    end

    assign fall_s    = clk_filt_d_r & ~clk_filt_r;
    assign timeout_s = (state_r != IDLE) && !fall_s && (idle_cnt_r == TO_LAST);
    assign err_s     = bad_frame_s | timeout_s;

    // Receiver state and frame registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            parity_r  <= 1'b0;
        end else begin
            state_r   <= state_n;
            bit_cnt_r <= bit_cnt_n;
            shift_r   <= shift_n;
            parity_r  <= parity_n;
        end
    end

    // Idle watchdog: any fall restarts it, a stalled frame expires it
    always_ff @(posedge clk) begin
        if (reset || state_r == IDLE || fall_s || timeout_s) begin
            idle_cnt_r <= '0;
        end else begin
            idle_cnt_r <= idle_cnt_r + IDLE_ONE;
        end
    end

    // Receiver next-state logic
    always_comb begin
        state_n     = state_r;
        bit_cnt_n   = bit_cnt_r;
        shift_n     = shift_r;
        parity_n    = parity_r;
        good_s      = 1'b0;
        bad_frame_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s && !data_filt_r) begin
                    bit_cnt_n = 3'd0;
                    state_n   = SHIFT;
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                if (fall_s) begin
                    shift_n[bit_cnt_r] = data_filt_r;
                    bit_cnt_n          = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_n = PARITY;
                    end else begin
                        state_n = SHIFT;
                    end
                end else begin
                    state_n = SHIFT;
                end
            end
            PARITY: begin
                if (fall_s) begin
                    parity_n = data_filt_r;
                    state_n  = STOP;
                end else begin
                    state_n = PARITY;
                end
            end
            STOP: begin
                if (fall_s) begin
                    state_n = IDLE;
                    if (data_filt_r && odd_parity_ok(shift_r, parity_r)) begin
                        good_s = 1'b1;
                    end else begin
                        bad_frame_s = 1'b1;
                    end
                end else begin
                    state_n = STOP;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (timeout_s) begin
            state_n = IDLE;
        end else begin
            state_n = state_n;
        end
    end

    // Scan-code decoder and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_r        <= 1'b0;
            brk_r        <= 1'b0;
            key_held_r   <= 4'b0000;
            code_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            code_byte_r  <= 8'h00;
            last_codes_r <= 32'h0000_0000;
        end else begin
            code_valid_r <= good_s;
            frame_err_r  <= err_s;
            if (good_s) begin
                code_byte_r  <= shift_r;
                last_codes_r <= {last_codes_r[23:0], shift_r};
                if (shift_r == 8'hE0) begin
                    ext_r <= 1'b1;
                end else if (shift_r == 8'hF0) begin
                    brk_r <= 1'b1;
                end else begin
                    case ({ext_r, shift_r})
                        9'h01D:  key_held_r[3] <= ~brk_r;
                        9'h01B:  key_held_r[2] <= ~brk_r;
                        9'h175:  key_held_r[1] <= ~brk_r;
                        9'h172:  key_held_r[0] <= ~brk_r;
                        default: key_held_r    <= key_held_r;
                    endcase
                    ext_r <= 1'b0;
                    brk_r <= 1'b0;
                end
            end else if (err_s) begin
                ext_r <= 1'b0;
                brk_r <= 1'b0;
            end else begin
                ext_r <= ext_r;
                brk_r <= brk_r;
            end
        end
    end

    assign key_held   = key_held_r;
    assign code_valid = code_valid_r;
    assign code_byte  = code_byte_r;
    assign last_codes = last_codes_r;
    assign frame_err  = frame_err_r;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: frames are bit-banged on the PS/2 lines and every
// output is compared against hand-computed values with immediate assertions.
module tb_ps2_key_tracker;
    localparam int HALF = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [3:0]  key_held;
    logic        code_valid;
    logic [7:0]  code_byte;
    logic [31:0] last_codes;
    logic        frame_err;

    int n_vec = 0;
    int n_miss = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int cv0, fe0;

    ps2_key_tracker #(.FILTER_LEN(8), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_held(key_held), .code_valid(code_valid), .code_byte(code_byte),
        .last_codes(last_codes), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (code_valid) cv_cnt++;
            if (frame_err) fe_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ bad_par);
        send_bit(1'b1);
        repeat (HALF) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_key", {28'd0, key_held}, 32'h0);
        check("rst_cv", {31'd0, code_valid}, 32'h0);
        check("rst_byte", {24'd0, code_byte}, 32'h0);
        check("rst_hist", last_codes, 32'h0);
        check("rst_err", {31'd0, frame_err}, 32'h0);
        check("rst_filt", {30'd0, dut.clk_filt_r, dut.data_filt_r}, 32'h3);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("idle_pulses", cv_cnt + fe_cnt, 32'd0);

        send_frame(8'h1D, 1'b0);
        check("w_press", {28'd0, key_held}, 32'h8);
        check("w_byte", {24'd0, code_byte}, 32'h1D);
        send_frame(8'hF0, 1'b0);
        check("w_f0_key", {28'd0, key_held}, 32'h8);
        send_frame(8'h1D, 1'b0);
        check("w_release", {28'd0, key_held}, 32'h0);
        check("w_hist", last_codes, 32'h001DF01D);
        check("w_cv_cnt", cv_cnt, 32'd3);

        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("rup_press", {28'd0, key_held}, 32'h2);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h72, 1'b0);
        check("rdn_press", {28'd0, key_held}, 32'h3);
        check("ext_hist", last_codes, 32'hE075E072);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("rup_release", {28'd0, key_held}, 32'h1);
        check("extbrk_hist", last_codes, 32'h72E0F075);
        send_frame(8'h75, 1'b0);
        check("kp8_key", {28'd0, key_held}, 32'h1);
        check("kp8_byte", {24'd0, code_byte}, 32'h75);

        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(8'hF0, 1'b1);
        check("par_err_cnt", fe_cnt - fe0, 32'd1);
        check("par_hist", last_codes, 32'hE0F07575);
        send_frame(8'h1B, 1'b0);
        check("par_s_press", {28'd0, key_held}, 32'h5);
        check("par_hist2", last_codes, 32'hF075751B);
        check("par_cv_cnt", cv_cnt - cv0, 32'd1);

        fe0 = fe_cnt; cv0 = cv_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        repeat (1200) @(posedge clk);
        @(negedge clk);
        check("to_err_cnt", fe_cnt - fe0, 32'd1);
        check("to_cv_cnt", cv_cnt - cv0, 32'd0);
        check("to_state_idle", {30'd0, dut.state_r}, 32'd0);
        check("to_key", {28'd0, key_held}, 32'h5);
        send_frame(8'h1D, 1'b0);
        check("to_w_press", {28'd0, key_held}, 32'hD);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1D, 1'b0);
        check("e0_1d_key", {28'd0, key_held}, 32'hD);
        check("e0_1d_hist", last_codes, 32'h1DE0F01D);

        cv0 = cv_cnt; fe0 = fe_cnt;
        for (int g = 0; g < 5; g++) begin
            ps2_clk = 1'b0;
            repeat (3) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (20) @(posedge clk);
        end
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("gl_cv", cv_cnt - cv0, 32'd0);
        check("gl_fe", fe_cnt - fe0, 32'd0);
        check("gl_state", {30'd0, dut.state_r}, 32'd0);
        check("gl_key", {28'd0, key_held}, 32'hD);
        check("gl_hist", last_codes, 32'h1DE0F01D);
        check("gl_byte", {24'd0, code_byte}, 32'h1D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
